// File: rtl/ama_riscv_fwd_scoreboard_pkg.sv
// Shared types for operand forwarding and the pending-write scoreboard.
// Holds the register address type, the bypass-select and hazard structs, the
// scoreboard counter type, and the register-pair mapping helper.
package ama_riscv_fwd_scoreboard_pkg;

  localparam int RF_ADDR_W  = 5;
  localparam int SB_MAX_LAT = 7;
  localparam int SB_CNT_W   = $clog2(SB_MAX_LAT + 1);

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [SB_CNT_W-1:0]  sb_cnt_t;

  localparam rf_addr_t RF_X0_ZERO = '0;

  // Bypass select for one operand: which stage and which half of a pair.
  typedef struct packed {
    logic on_rdp;    // value comes from the paired-register write
    logic from_wbk;  // value comes from writeback rather than mem
  } fwd_be_t;

  typedef struct packed {
    logic to_exe;    // hold the decode/exe boundary this cycle
  } hazard_t;

  // Paired register of a double-width write: partner within the even/odd pair.
  function automatic rf_addr_t get_rdp(input rf_addr_t rd);
    return {rd[RF_ADDR_W-1:1], ~rd[0]};
  endfunction

endpackage

// File: rtl/ama_riscv_sb_entry.sv
// One scoreboard entry: busy flag plus remaining-latency counter.
// Latency: set/clear/decrement visible the cycle after the edge.
// Backpressure: freeze holds the counter; set and clear still apply.
// Ports: clk, rst_n (sync, active low), set/set_cnt (issue), clr (retire),
//        freeze (hold countdown), busy/cnt (current state).
module ama_riscv_sb_entry #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [CNT_W-1:0] set_cnt,
  input  logic             clr,
  input  logic             freeze,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  logic             busy_d, busy_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Later assignments win: issue over retire over countdown.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q && (cnt_q != '0) && !freeze) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (clr) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end
    if (set) begin
      busy_d = 1'b1;
      cnt_d  = set_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/ama_riscv_fwd_scoreboard.sv
// Operand forwarding unit with a per-register pending-write scoreboard.
// Latency: fwd_en/fwd_sel/hazard combinational; scoreboard updates next cycle.
// Backpressure: hazard.to_exe stalls issue; a stalled issue is not recorded.
// Ports: issue (iss_*), freeze, flush, writeback retire (wb_*), mem/wbk stage
//        destinations (rd_*_mem/wbk), per-operand rs_dec/src_used in,
//        fwd_en/fwd_sel/hazard out, busy_vec debug out.
module ama_riscv_fwd_scoreboard
  import ama_riscv_fwd_scoreboard_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int NUM_REGS  = 32,
  parameter int MAX_LAT   = 7,
  parameter int PAIRED_EN = 1,
  localparam int LAT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       iss_valid,
  input  rf_addr_t                   iss_rd,
  input  logic                       iss_rd_we,
  input  logic                       iss_rdp_we,
  input  logic [LAT_W-1:0]           iss_lat,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic                       wb_valid,
  input  rf_addr_t                   wb_rd,
  input  logic                       wb_rd_we,
  input  logic                       wb_rdp_we,
  input  rf_addr_t                   rd_mem,
  input  rf_addr_t                   rd_wbk,
  input  logic                       rd_we_mem,
  input  logic                       rdp_we_mem,
  input  logic                       rd_we_wbk,
  input  logic                       rdp_we_wbk,
  input  rf_addr_t [NUM_SRC-1:0]     rs_dec,
  input  logic [NUM_SRC-1:0]         src_used,
  output logic [NUM_SRC-1:0]         fwd_en,
  output fwd_be_t [NUM_SRC-1:0]      fwd_sel,
  output hazard_t                    hazard,
  output logic [NUM_REGS-1:0]        busy_vec
);

  // Pair writes disappear entirely when pairing is disabled.
  logic iss_rdp_we_i, wb_rdp_we_i, rdp_we_mem_i, rdp_we_wbk_i;
  assign iss_rdp_we_i = (PAIRED_EN != 0) && iss_rdp_we;
  assign wb_rdp_we_i  = (PAIRED_EN != 0) && wb_rdp_we;
  assign rdp_we_mem_i = (PAIRED_EN != 0) && rdp_we_mem;
  assign rdp_we_wbk_i = (PAIRED_EN != 0) && rdp_we_wbk;

  rf_addr_t iss_rdp, wb_rdp, rdp_mem, rdp_wbk;
  assign iss_rdp = get_rdp(iss_rd);
  assign wb_rdp  = get_rdp(wb_rd);
  assign rdp_mem = get_rdp(rd_mem);
  assign rdp_wbk = get_rdp(rd_wbk);

  logic iss_fire;
  assign iss_fire = iss_valid && !flush && !hazard.to_exe;

  // ---------------------------------------------------------------------------
  // Scoreboard entries; x0 has no entry and reads as never busy.
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] busy_w;
  logic [LAT_W-1:0]    cnt_w [1:NUM_REGS-1];

  assign busy_w[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    localparam rf_addr_t R = rf_addr_t'(r);
    logic set_r, clr_r;

    // r >= 1, so a match on iss_rd already implies rd != x0.
    assign set_r = iss_fire &&
                   ((iss_rd_we && (iss_rd == R)) || (iss_rdp_we_i && (iss_rdp == R)));
    assign clr_r = wb_valid &&
                   ((wb_rd_we && (wb_rd == R)) || (wb_rdp_we_i && (wb_rdp == R)));

    ama_riscv_sb_entry #(
      .CNT_W (LAT_W)
    ) u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (set_r),
      .set_cnt (iss_lat),
      .clr     (clr_r),
      .freeze  (freeze),
      .busy    (busy_w[r]),
      .cnt     (cnt_w[r])
    );
  end

  assign busy_vec = busy_w;

  // ---------------------------------------------------------------------------
  // Per-operand comparators, bypass select and stall contribution.
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] src_haz;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    rf_addr_t         rs;
    logic             nz;
    logic             mem_rd_m, mem_rdp_m, wbk_rd_m, wbk_rdp_m;
    logic             mem_m, wbk_m;
    logic             rs_busy;
    logic [LAT_W-1:0] rs_cnt;
    fwd_be_t          sel;

    assign rs = rs_dec[i];
    assign nz = (rs != RF_X0_ZERO) && src_used[i];

    assign mem_rd_m  = rd_we_mem    && (rs == rd_mem);
    assign mem_rdp_m = rdp_we_mem_i && (rs == rdp_mem);
    assign wbk_rd_m  = rd_we_wbk    && (rs == rd_wbk);
    assign wbk_rdp_m = rdp_we_wbk_i && (rs == rdp_wbk);
    assign mem_m     = mem_rd_m || mem_rdp_m;
    assign wbk_m     = wbk_rd_m || wbk_rdp_m;

    always_comb begin
      rs_busy = 1'b0;
      rs_cnt  = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (rs == rf_addr_t'(r)) begin
          rs_busy = busy_w[r];
          rs_cnt  = cnt_w[r];
        end
      end
    end

    // mem is the younger producer, so it wins over wbk.
    always_comb begin
      sel.from_wbk = !mem_m;
      sel.on_rdp   = 1'b0;
      if (mem_m) begin
        sel.on_rdp = !mem_rd_m;
      end else if (wbk_m) begin
        sel.on_rdp = !wbk_rd_m;
      end
    end

    assign fwd_sel[i] = sel;
    assign fwd_en[i]  = rst_n && nz && (mem_m || wbk_m);

    // A busy source with no visible producer stalls conservatively: its value
    // may be in a stage that is not a bypass point.
    assign src_haz[i] = nz && rs_busy && ((rs_cnt != '0) || !(mem_m || wbk_m));
  end

  assign hazard = hazard_t'{to_exe: rst_n && (|src_haz)};

endmodule

// File: tb/tb_ama_riscv_fwd_scoreboard.sv
module tb_ama_riscv_fwd_scoreboard;
  import ama_riscv_fwd_scoreboard_pkg::*;

  localparam int NUM_SRC  = 2;
  localparam int NUM_REGS = 32;
  localparam int LAT_W    = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   iss_valid, iss_rd_we, iss_rdp_we;
  rf_addr_t               iss_rd;
  logic [LAT_W-1:0]       iss_lat;
  logic                   freeze, flush;
  logic                   wb_valid, wb_rd_we, wb_rdp_we;
  rf_addr_t               wb_rd, rd_mem, rd_wbk;
  logic                   rd_we_mem, rdp_we_mem, rd_we_wbk, rdp_we_wbk;
  rf_addr_t [NUM_SRC-1:0] rs_dec;
  logic [NUM_SRC-1:0]     src_used;
  logic [NUM_SRC-1:0]     fwd_en;
  fwd_be_t [NUM_SRC-1:0]  fwd_sel;
  hazard_t                hazard;
  logic [NUM_REGS-1:0]    busy_vec;

  always #5 clk = ~clk;

  ama_riscv_fwd_scoreboard #(
    .NUM_SRC(NUM_SRC), .NUM_REGS(NUM_REGS), .MAX_LAT(7), .PAIRED_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
    .iss_rdp_we(iss_rdp_we), .iss_lat(iss_lat),
    .freeze(freeze), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rd_we(wb_rd_we), .wb_rdp_we(wb_rdp_we),
    .rd_mem(rd_mem), .rd_wbk(rd_wbk),
    .rd_we_mem(rd_we_mem), .rdp_we_mem(rdp_we_mem),
    .rd_we_wbk(rd_we_wbk), .rdp_we_wbk(rdp_we_wbk),
    .rs_dec(rs_dec), .src_used(src_used),
    .fwd_en(fwd_en), .fwd_sel(fwd_sel), .hazard(hazard), .busy_vec(busy_vec)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending writes as plain per-register integers.
  int m_busy [32];
  int m_cnt  [32];

  logic                   obs_haz;
  logic [NUM_SRC-1:0]     obs_en;
  logic [2*NUM_SRC-1:0]   obs_sel;

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = (m_busy[r] != 0);
    return v;
  endfunction

  // Producers in priority order: mem rd, mem pair, wbk rd, wbk pair.
  task automatic model_out(output logic [NUM_SRC-1:0] e_en,
                           output logic [2*NUM_SRC-1:0] e_sel,
                           output logic e_haz);
    rf_addr_t c_reg [4];
    logic     c_we  [4];
    c_reg = '{rd_mem, rd_mem ^ 5'd1, rd_wbk, rd_wbk ^ 5'd1};
    c_we  = '{rd_we_mem, rdp_we_mem, rd_we_wbk, rdp_we_wbk};
    e_en  = '0;
    e_sel = '0;
    e_haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int  pick = -1;
      bit  nz;
      for (int k = 0; k < 4; k++)
        if (pick < 0 && c_we[k] && c_reg[k] == rs_dec[i]) pick = k;
      nz = (rs_dec[i] != 0) && src_used[i];
      e_sel[2*i+1] = (pick == 1 || pick == 3);
      e_sel[2*i]   = !(pick == 0 || pick == 1);
      e_en[i]      = rst_n && nz && (pick >= 0);
      if (rst_n && nz && m_busy[rs_dec[i]] != 0 && (m_cnt[rs_dec[i]] != 0 || pick < 0))
        e_haz = 1'b1;
    end
  endtask

  task automatic model_update(input logic e_haz);
    rf_addr_t p;
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_cnt[r] = 0; end
      return;
    end
    if (!freeze)
      for (int r = 0; r < 32; r++) if (m_busy[r] != 0 && m_cnt[r] > 0) m_cnt[r]--;
    if (wb_valid) begin
      p = wb_rd ^ 5'd1;
      if (wb_rd_we)  m_busy[wb_rd] = 0;
      if (wb_rdp_we) m_busy[p] = 0;
    end
    if (iss_valid && !flush && !e_haz) begin
      p = iss_rd ^ 5'd1;
      if (iss_rd_we && iss_rd != 0) begin m_busy[iss_rd] = 1; m_cnt[iss_rd] = int'(iss_lat); end
      if (iss_rdp_we && p != 0)     begin m_busy[p] = 1;      m_cnt[p] = int'(iss_lat);      end
    end
  endtask

  // One cycle: compare combinational outputs mid-cycle, then advance the model.
  task automatic tick();
    logic [NUM_SRC-1:0]   e_en;
    logic [2*NUM_SRC-1:0] e_sel;
    logic                 e_haz;
    @(negedge clk);
    model_out(e_en, e_sel, e_haz);
    obs_haz = hazard.to_exe;
    obs_en  = fwd_en;
    obs_sel = fwd_sel;
    chk("hazard",   64'(hazard.to_exe), 64'(e_haz));
    chk("fwd_en",   64'(fwd_en),        64'(e_en));
    chk("fwd_sel",  64'(fwd_sel),       64'(e_sel));
    chk("busy_vec", 64'(busy_vec),      64'(model_busy_vec()));
    @(posedge clk);
    model_update(e_haz);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_rd = 0; iss_rd_we = 0; iss_rdp_we = 0; iss_lat = 0;
    freeze = 0; flush = 0;
    wb_valid = 0; wb_rd = 0; wb_rd_we = 0; wb_rdp_we = 0;
    rd_mem = 0; rd_wbk = 0; rd_we_mem = 0; rdp_we_mem = 0; rd_we_wbk = 0; rdp_we_wbk = 0;
    rs_dec = '0; src_used = '0;
  endtask

  task automatic issue(input rf_addr_t rd, input logic rdp, input int lat);
    idle();
    iss_valid = 1; iss_rd = rd; iss_rd_we = 1; iss_rdp_we = rdp; iss_lat = LAT_W'(lat);
    tick();
  endtask

  task automatic retire(input rf_addr_t rd, input logic rdp);
    idle();
    wb_valid = 1; wb_rd = rd; wb_rd_we = 1; wb_rdp_we = rdp;
    tick();
    idle();
  endtask

  // Reader of rs presented until it issues (rd_mem=rs once the result lands);
  // returns the number of stalled cycles, bounded.
  task automatic stall_count(input rf_addr_t rs, input int fz_start, input int fz_len,
                             output int n);
    n = 0;
    idle();
    iss_valid = 1; rs_dec[0] = rs; src_used = 2'b01; rd_mem = rs; rd_we_mem = 1;
    for (int k = 0; k < 20; k++) begin
      freeze = (k >= fz_start && k < fz_start + fz_len);
      tick();
      if (!obs_haz) break;
      n++;
    end
    idle();
  endtask

  initial begin
    int n;
    for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_cnt[r] = 0; end

    // Reset with an issue and a forwarding match presented.
    idle();
    rst_n = 0;
    iss_valid = 1; iss_rd = 5'd5; iss_rd_we = 1; iss_lat = 3'd3;
    rs_dec[0] = 5'd5; src_used = 2'b01; rd_mem = 5'd5; rd_we_mem = 1;
    tick();
    tick();
    chk("rst_hazard", 64'(obs_haz), 64'(0));
    chk("rst_fwd_en", 64'(obs_en), 64'(0));
    chk("rst_busy",   64'(busy_vec), 64'(0));
    rst_n = 1;
    idle();
    tick();
    chk("post_rst_busy", 64'(busy_vec), 64'(0));

    // Latency-3 producer: three stall cycles, then forward from mem.
    issue(5'd5, 0, 3);
    stall_count(5'd5, 99, 0, n);
    chk("lat3_stall", 64'(n), 64'(3));
    chk("lat3_fwd_en", 64'(obs_en[0]), 64'(1));
    chk("lat3_fwd_sel", 64'(obs_sel[1:0]), 64'(2'b00));
    retire(5'd5, 0);

    // Same with two freeze cycles mid-count.
    issue(5'd5, 0, 3);
    stall_count(5'd5, 1, 2, n);
    chk("freeze_stall", 64'(n), 64'(5));
    retire(5'd5, 0);

    // Paired write x10/x11; read the pair half from mem.
    issue(5'd10, 1, 0);
    chk("pair_busy", 64'({busy_vec[11], busy_vec[10]}), 64'(2'b11));
    idle();
    iss_valid = 1; rs_dec[0] = 5'd11; src_used = 2'b01;
    rd_mem = 5'd10; rd_we_mem = 1; rdp_we_mem = 1;
    tick();
    chk("pair_haz", 64'(obs_haz), 64'(0));
    chk("pair_en", 64'(obs_en[0]), 64'(1));
    chk("pair_sel", 64'(obs_sel[1:0]), 64'(2'b10));
    retire(5'd10, 1);
    chk("pair_retired", 64'({busy_vec[11], busy_vec[10]}), 64'(2'b00));

    // mem beats wbk; x0 and unused operands never forward or stall.
    idle();
    rs_dec[0] = 5'd2; rs_dec[1] = 5'd0; src_used = 2'b11;
    rd_mem = 5'd2; rd_we_mem = 1; rd_wbk = 5'd2; rd_we_wbk = 1;
    tick();
    chk("prio_sel", 64'(obs_sel[1:0]), 64'(2'b00));
    chk("x0_en", 64'(obs_en[1]), 64'(0));
    issue(5'd2, 0, 5);
    idle();
    iss_valid = 1; rs_dec[0] = 5'd2; src_used = 2'b00; rd_mem = 5'd2; rd_we_mem = 1;
    tick();
    chk("unused_haz", 64'(obs_haz), 64'(0));
    chk("unused_en", 64'(obs_en[0]), 64'(0));
    retire(5'd2, 0);

    // Retire and re-issue of x7 in the same cycle: issue wins, count 2.
    issue(5'd7, 0, 0);
    idle();
    wb_valid = 1; wb_rd = 5'd7; wb_rd_we = 1;
    iss_valid = 1; iss_rd = 5'd7; iss_rd_we = 1; iss_lat = 3'd2;
    tick();
    chk("reissue_busy", 64'(busy_vec[7]), 64'(1));
    stall_count(5'd7, 99, 0, n);
    chk("reissue_stall", 64'(n), 64'(2));
    retire(5'd7, 0);

    // Flushed issue leaves no entry.
    idle();
    iss_valid = 1; flush = 1; iss_rd = 5'd9; iss_rd_we = 1; iss_lat = 3'd4;
    tick();
    chk("flush_busy", 64'(busy_vec[9]), 64'(0));

    // Randomized traffic over a small register window to force collisions.
    for (int c = 0; c < 500; c++) begin
      rst_n      = ($urandom_range(0, 63) != 0);
      iss_valid  = $urandom_range(0, 1);
      iss_rd     = rf_addr_t'($urandom_range(0, 15));
      iss_rd_we  = ($urandom_range(0, 3) != 0);
      iss_rdp_we = ($urandom_range(0, 4) == 0);
      iss_lat    = LAT_W'($urandom_range(0, 7));
      freeze     = ($urandom_range(0, 6) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      wb_valid   = $urandom_range(0, 1);
      wb_rd      = rf_addr_t'($urandom_range(0, 15));
      wb_rd_we   = $urandom_range(0, 1);
      wb_rdp_we  = ($urandom_range(0, 3) == 0);
      rd_mem     = rf_addr_t'($urandom_range(0, 15));
      rd_wbk     = rf_addr_t'($urandom_range(0, 15));
      rd_we_mem  = $urandom_range(0, 1);
      rdp_we_mem = ($urandom_range(0, 3) == 0);
      rd_we_wbk  = $urandom_range(0, 1);
      rdp_we_wbk = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_SRC; i++) rs_dec[i] = rf_addr_t'($urandom_range(0, 15));
      src_used   = NUM_SRC'($urandom_range(0, 3));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ama_riscv_fwd_scoreboard.md
Name: ama_riscv_fwd_scoreboard

Overview:
- Parametrised successor to the two-source operand forwarding unit.
- Adds a per-register pending-write scoreboard with latency countdown, so variable-latency units (multiply, divide, future SIMD) stall dependents only until the result reaches a bypass point. Fixed mem/wbk-only hazard rules are no longer used.
- Generalised to NUM_SRC source operands with paired-register (rdp) support.
- Sits between decode and execute. Drives bypass-select and stall for every source operand.

Parameters:
- NUM_SRC, 2: source operands checked per instruction (2 or 3).
- NUM_REGS, 32: architectural integer registers.
- MAX_LAT, 7: largest issue latency in cycles; LAT_W = $clog2(MAX_LAT+1).
- PAIRED_EN, 1: 0 ties all rdp write-enables inactive internally.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- iss_valid  in  1  instruction leaves decode into exe this cycle
- iss_rd  in  5  destination register
- iss_rd_we  in  1  writes rd
- iss_rdp_we  in  1  also writes paired register get_rdp(iss_rd)
- iss_lat  in  LAT_W  cycles until result reaches mem-stage bypass
- freeze  in  1  dcache stall; hold all counters
- flush  in  1  squash the issue in this cycle
- wb_valid  in  1  writeback commits this cycle
- wb_rd  in  5  committed rd
- wb_rd_we, wb_rdp_we  in  1 each  committed write-enables
- rd_mem, rd_wbk  in  5 each  stage destinations
- rd_we_mem, rdp_we_mem, rd_we_wbk, rdp_we_wbk  in  1 each
- rs_dec  in  NUM_SRC x 5  source addresses
- src_used  in  NUM_SRC  operand actually read by the instruction
- fwd_en  out  NUM_SRC  use bypass for operand i
- fwd_sel  out  NUM_SRC x fwd_be_t  {on_rdp, from_wbk}
- hazard  out  hazard_t  .to_exe = stall decode/exe boundary
- busy_vec  out  NUM_REGS  debug: pending-write flags

Behaviour:
- State per register r: busy[r], cnt[r] (LAT_W bits). x0 is never busy.
- Reset (rst_n low at posedge): all busy=0, cnt=0. While rst_n is low, hazard.to_exe=0 and fwd_en=0.
- Issue: iss_valid && !flush && !hazard.to_exe. For rd (if iss_rd_we, rd!=0) and rdp (if iss_rdp_we): next busy=1, cnt=iss_lat.
- iss_lat=0 is legal. The result is immediately in mem; the entry is set busy with cnt=0.
- Countdown: each cycle with !freeze, every busy entry with cnt>0 decrements, saturating at 0. With freeze high, counters hold.
- Retire: wb_valid clears busy for wb_rd (if wb_rd_we) and get_rdp(wb_rd) (if wb_rdp_we).
- Issue and retire to the same register in the same cycle: issue wins (busy=1, new cnt).
- Match for operand i: nz_i = rs_dec[i]!=0 && src_used[i].
  - mem match: (rs==rd_mem && rd_we_mem) or (rs==get_rdp(rd_mem) && rdp_we_mem).
  - wbk match: the same test against the wbk stage fields.
- Forwarding, combinational from current state:
  - fwd_en[i] = nz_i && (mem match || wbk match).
  - mem has priority over wbk. fwd_sel.from_wbk = !mem match.
  - fwd_sel.on_rdp is set when the selected match was on the paired register.
- hazard.to_exe = OR over i of nz_i && busy[rs_i] && (cnt[rs_i]!=0 || no mem/wbk match). The no-match case is a conservative stall.
- Stalled issue is not recorded. Re-presentation next cycle is expected.
- Flush affects only the current issue. Entries already recorded stay until retire, because those instructions are past the flush point.
- Latency: forwarding/hazard outputs are same-cycle combinational. Scoreboard updates are visible the cycle after the issue edge.

Decomposition:
- Package (existing ama_riscv_defines): rf_addr_t, fwd_be_t, hazard_t, get_rdp(), RF_X0_ZERO. Add sb_cnt_t.
- Sub-module ama_riscv_sb_entry (busy+cnt, set/clear/decrement/freeze priority), generated NUM_REGS-1 times.
- Top level holds the comparators and the NUM_SRC generate loop.

Test Plan:
- Reset with rst_n=0 while iss_valid=1 -> busy_vec=0, hazard=0, fwd_en=0; first post-reset cycle: no entry set.
- Issue x5 with iss_lat=3, next instruction reads x5 -> hazard high for 3 cycles. Cycle 4: rd_mem=5 gives fwd_en[0]=1, fwd_sel=2'b00, hazard=0.
- Same as previous, with freeze high for 2 cycles mid-count -> hazard extends by exactly 2 cycles.
- Issue x10 with iss_rdp_we=1; read x11 once rd_mem=10 -> fwd_sel={1,0}. After the wbk commit of x10/x11: busy_vec[10]=busy_vec[11]=0.
- x2 matching both rd_mem and rd_wbk -> fwd_sel.from_wbk=0. rs=x0 or src_used=0 -> fwd_en=0, no hazard.
- wb retire of x7 and new issue to x7 with lat=2 in the same cycle -> busy_vec[7]=1, cnt=2. flush with iss_valid -> no entry set.
